// File: rtl/rv_seq_ctrl.sv
// Multi-cycle RV32 instruction sequencer: fetches over req/ack, decodes the opcode,
// strobes execute/write-back, computes next-PC and parks in HALT or a sticky FAULT.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | out of reset, fetch begins on the next clock
// S_FETCH  | imem_req high at pc, waiting for ack (bounded by timeout)
// S_DECODE | IR latched, opcode legality check
// S_EXEC   | ir_valid strobe, next_pc computed and registered
// S_WB     | rf_we strobe, pc/retired_cnt updated, halt sampled
// S_HALT   | parked at an instruction boundary until halt drops
// S_FAULT  | sticky fault, left only by reset
module rv_seq_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] PC_RESET     = '0,
    parameter int              IMEM_TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [31:0]     i_imem_rdata,
    output logic [31:0]     o_ir,
    output logic            o_ir_valid,
    output logic            o_alu_src_imm,
    output logic            o_rf_we,
    output logic [4:0]      o_rd_addr,
    input  logic            i_br_taken,
    input  logic            i_halt,
    output logic            o_halted,
    output logic            o_fault,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_retired_cnt
);

    localparam int TW = $clog2(IMEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(IMEM_TIMEOUT - 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_next_pc;
    logic [31:0]     r_retired;
    logic [TW-1:0]   r_tmo;

    logic [6:0]      w_opc;
    logic            w_legal;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_next_pc;

    assign w_opc      = r_ir[6:0];
    assign w_imm_b    = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_j    = {{(XLEN-21){r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_pc_plus4 = r_pc + XLEN'(4);

    always_comb begin
        w_legal = 1'b0;
        case (w_opc)
            OPC_OP, OPC_OP_IMM, OPC_STORE, OPC_BRANCH,
            OPC_LUI, OPC_JAL, OPC_LOAD: w_legal = 1'b1;
            default:                    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc = w_pc_plus4;
        if (w_opc == OPC_BRANCH && i_br_taken) begin
            w_next_pc = r_pc + w_imm_b;
        end else if (w_opc == OPC_JAL) begin
            w_next_pc = r_pc + w_imm_j;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_imem_req    = 1'b0;
        o_ir_valid    = 1'b0;
        o_alu_src_imm = 1'b0;
        o_rf_we       = 1'b0;
        o_halted      = 1'b0;
        o_fault       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                o_imem_req = 1'b1;
                // ack takes priority over an expiring timeout
                if (i_imem_ack) begin
                    w_state_nxt = S_DECODE;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                w_state_nxt = w_legal ? S_EXEC : S_FAULT;
            end
            S_EXEC: begin
                o_ir_valid    = 1'b1;
                o_alu_src_imm = (w_opc != OPC_OP);
                w_state_nxt   = (w_next_pc[1:0] != 2'b00) ? S_FAULT : S_WB;
            end
            S_WB: begin
                o_alu_src_imm = (w_opc != OPC_OP);
                o_rf_we       = (w_opc != OPC_STORE) && (w_opc != OPC_BRANCH) &&
                                (r_ir[11:7] != 5'd0);
                w_state_nxt   = i_halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                o_halted = 1'b1;
                if (!i_halt) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FAULT: begin
                o_fault = 1'b1;
            end
            default: begin
                w_state_nxt = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ir      <= '0;
            r_pc      <= PC_RESET;
            r_next_pc <= PC_RESET;
            r_retired <= '0;
            r_tmo     <= '0;
        end else begin
            if (r_state == S_FETCH) begin
                if (i_imem_ack) begin
                    r_ir <= i_imem_rdata;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
            end else begin
                r_tmo <= '0;
            end
            if (r_state == S_EXEC) begin
                r_next_pc <= w_next_pc;
            end
            if (r_state == S_WB) begin
                r_pc      <= r_next_pc;
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_pc          = r_pc;
    assign o_ir          = r_ir;
    assign o_rd_addr     = r_ir[11:7];
    assign o_retired_cnt = r_retired;

endmodule
